// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX queue among N_REQ byte-stream requesters,
// locking the queue per message. Optional stall timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               send_req,
  output logic [7:0]         send_data,
  input  logic               txq_full,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    owner_q;
  logic [BW-1:0]    burst_cnt_q;

  logic             next_found;
  logic [IW-1:0]    next_idx;
  logic             owner_valid;
  logic             owner_last;
  logic             accept;
  logic             burst_hit;
  logic             timeout_rel;
  logic             release_now;

  assign grant = grant_q;
  assign busy  = busy_q;

  // Walk downward so the candidate closest to rr_ptr+1 is the one left standing.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      int unsigned cand;
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (req_valid[cand]) begin
        next_found = 1'b1;
        next_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    owner_valid = req_valid[owner_q];
    owner_last  = req_last[owner_q];
    req_ready   = '0;
    send_req    = 1'b0;
    send_data   = '0;
    if (busy_q) begin
      req_ready[owner_q] = ~txq_full;
      send_req           = owner_valid & ~txq_full;
      send_data          = req_data[8*int'(owner_q) +: 8];
    end
  end

  assign accept    = send_req;
  assign burst_hit = (MAX_BURST != 0) && ((32'(burst_cnt_q) + 32'd1) == MAX_BURST);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt_q;
  assign timeout_rel = busy_q & ~owner_valid & (stall_cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (state_q == StIdle || owner_valid) begin
      stall_cnt_q <= '0;
    end else if (!timeout_rel) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`else
  assign timeout_rel = 1'b0;
`endif

  assign release_now = (accept & (owner_last | burst_hit)) | timeout_rel;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= IW'(N_REQ - 1);
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (next_found) begin
            state_q     <= StGrant;
            grant_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << next_idx;
            owner_q     <= next_idx;
            busy_q      <= 1'b1;
            burst_cnt_q <= '0;
          end
        end
        StGrant: begin
          if (accept && burst_cnt_q != '1) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
          if (release_now) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= owner_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, an ordered scoreboard of
// expected {source, byte} writes, and immediate assertions at every comparison point.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] req_valid;
  logic [15:0] req_data;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic       send_req;
  logic [7:0] send_data;
  logic       txq_full;
  logic [1:0] grant;
  logic       busy;

  uart_tx_arbiter #(.N_REQ(2), .MAX_BURST(4), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .send_req(send_req), .send_data(send_data), .txq_full(txq_full),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] src0[$];   // {last, data}
  logic [8:0] src1[$];
  logic [8:0] exp_q[$];  // {source, data}
  logic [1:0] src_en;
  logic       s_send, s_busy;
  logic [1:0] s_grant, s_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    req_valid = 2'b00; req_data = '0; req_last = 2'b00;
    if (src_en[0] && src0.size() > 0) begin
      req_valid[0] = 1'b1; req_data[7:0] = src0[0][7:0]; req_last[0] = src0[0][8];
    end
    if (src_en[1] && src1.size() > 0) begin
      req_valid[1] = 1'b1; req_data[15:8] = src1[0][7:0]; req_last[1] = src1[0][8];
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic last);
    if (s == 0) src0.push_back({last, d});
    else        src1.push_back({last, d});
    exp_q.push_back({s[0], d});
  endtask

  task automatic cycle();
    logic [1:0] acc;
    logic [8:0] e;
    drive();
    @(negedge clk);
    s_send = send_req; s_grant = grant; s_busy = busy; s_ready = req_ready;
    chk("send_while_full", 32'(send_req & txq_full), 0);
    chk("ready_not_owner", 32'(req_ready & ~grant), 0);
    if (send_req) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("send_data", 32'(send_data), 32'(e[7:0]));
        chk("send_owner", 32'(grant), 32'(e[8] ? 2'b10 : 2'b01));
      end
    end
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    if (acc[0]) void'(src0.pop_front());
    if (acc[1]) void'(src1.pop_front());
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_send", 32'(send_req), 0);
    chk("rst_ready", 32'(req_ready), 0);
    src0.delete(); src1.delete(); exp_q.delete();
    src_en = 2'b11; txq_full = 1'b0;
    drive();
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    src_en = 2'b11; txq_full = 1'b0;
    drive();
    do_reset();

    // Single 3-byte message from requester 0
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    cycle();
    chk("t1_arb_send", 32'(s_send), 0);
    chk("t1_arb_grant", 32'(s_grant), 0);
    cycle();
    chk("t1_grant", 32'(s_grant), 1);
    chk("t1_busy", 32'(s_busy), 1);
    chk("t1_send0", 32'(s_send), 1);
    cycle(); chk("t1_send1", 32'(s_send), 1);
    cycle(); chk("t1_send2", 32'(s_send), 1);
    cycle();
    chk("t1_rel_grant", 32'(s_grant), 0);
    chk("t1_rel_busy", 32'(s_busy), 0);
    chk("t1_rel_send", 32'(s_send), 0);
    chk("t1_drain", 32'(exp_q.size()), 0);

    // Round robin between two requesters, two messages each
    do_reset();
    push(0, 8'hA0, 0); push(0, 8'hA1, 1);
    push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    push(1, 8'hB2, 0); push(1, 8'hB3, 1);
    exp_q.delete();
    exp_q = '{9'h0A0, 9'h0A1, 9'h1B0, 9'h1B1, 9'h0A2, 9'h0A3, 9'h1B2, 9'h1B3};
    run_until_empty(60);

    // Burst quota of 4: req1 streams 10 unterminated bytes while req0 waits
    do_reset();
    for (int i = 0; i < 10; i++) src1.push_back({1'b0, 8'hD0 + 8'(i)});
    src0 = '{9'h0C0, 9'h1C1, 9'h0C2, 9'h1C3};
    exp_q = '{9'h1D0, 9'h1D1, 9'h1D2, 9'h1D3, 9'h0C0, 9'h0C1, 9'h1D4, 9'h1D5,
              9'h1D6, 9'h1D7, 9'h0C2, 9'h0C3, 9'h1D8, 9'h1D9};
    src_en = 2'b10;
    cycle();
    src_en = 2'b11;
    run_until_empty(80);

    // Backpressure mid-message
    do_reset();
    for (int i = 0; i < 5; i++) push(0, 8'hE0 + 8'(i), i == 4);
    cycle(); cycle(); cycle();
    txq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_full_send", 32'(s_send), 0);
      chk("t4_full_ready", 32'(s_ready), 0);
    end
    txq_full = 1'b0;
    run_until_empty(20);
    cycle();
    chk("t4_rel_grant", 32'(s_grant), 0);

    // Owner stalls after one byte while req1 waits
    do_reset();
    push(0, 8'hF0, 0);
    src0.push_back(9'h0F1); src0.push_back(9'h1F2);
    src1.push_back(9'h060); src1.push_back(9'h161);
    cycle(); cycle();
    src_en = 2'b10;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t5_hold", 32'(s_grant), 1);
    end
    cycle(); chk("t5_idle", 32'(s_grant), 0);
    exp_q.push_back(9'h160); exp_q.push_back(9'h161);
    cycle(); chk("t5_next", 32'(s_grant), 2);
    run_until_empty(10);
`else
    for (int i = 0; i < 110; i++) begin
      cycle();
      chk("t5_hold", 32'(s_grant), 1);
    end
    chk("t5_drain", 32'(exp_q.size()), 0);
`endif

    // Reset during a grant, then fresh contention
    do_reset();
    push(0, 8'h90, 0); push(0, 8'h91, 0);
    src0.push_back(9'h092); src0.push_back(9'h193);
    src1.push_back(9'h070); src1.push_back(9'h171);
    cycle(); cycle(); cycle();
    chk("t6_pre_busy", 32'(s_busy), 1);
    do_reset();
    push(0, 8'h30, 0); push(0, 8'h31, 1);
    push(1, 8'h50, 0); push(1, 8'h51, 1);
    cycle();
    cycle();
    chk("t6_first_owner", 32'(s_grant), 1);
    run_until_empty(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
